id_ex_stage_register: RTL

- Decode-to-execute pipeline register of the 32-bit MIPS-style datapath; sits directly downstream of the register file and consumes its ReadData1/ReadData2.
- Captures the decoded instruction, its operands and its control bits each cycle.
- Bypasses a same-cycle write-back to fix register-file write/read timing.
- Detects load-use hazards, then inserts a one-cycle bubble and stalls decode.
- Supports branch flush, downstream hold, and a saturating stall-cycle counter.

---
 rtl/id_ex_stage_register_pkg.sv | 36 +++
 rtl/id_ex_hazard_detect.sv | 38 +++
 rtl/id_ex_stage_register.sv | 129 ++++++++++++
 3 files changed

// File: rtl/id_ex_stage_register_pkg.sv
// Shared widths, the zero-register index and the ID/EX pipe record.
package id_ex_stage_register_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int CTRL_W     = 8;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // Everything the execute stage sees from this register.
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     readData1;
        logic [DATA_W-1:0]     readData2;
        logic [DATA_W-1:0]     imm;
        logic [DATA_W-1:0]     pcPlus4;
        logic [CTRL_W-1:0]     ctrl;
        logic                  memRead;
        logic                  regWrite;
    } idExRec_t;

    // A squashed slot: no valid instruction, no side effects.
    localparam idExRec_t BUBBLE = '0;

    // True when the write-back port is writing register idx this cycle.
    // Register 0 is hardwired, so a write to it never forwards.
    function automatic logic wbHits(input logic                  regWrite,
                                    input logic [REG_ADDR_W-1:0] writeReg,
                                    input logic [REG_ADDR_W-1:0] idx);
        return regWrite && (writeReg != REG_ZERO) && (writeReg == idx);
    endfunction

endpackage

// File: rtl/id_ex_hazard_detect.sv
// Combinational hazard logic: load-use detection, decode stall and the
// write-back forwarding selects for both capture and hold paths.
module id_ex_hazard_detect
    import id_ex_stage_register_pkg::*;
(
    input  logic                  Reset,
    input  logic                  ExValid,
    input  logic                  ExMemRead,
    input  logic [REG_ADDR_W-1:0] ExRs,
    input  logic [REG_ADDR_W-1:0] ExRt,
    input  logic                  IdValid,
    input  logic [REG_ADDR_W-1:0] IdRs,
    input  logic [REG_ADDR_W-1:0] IdRt,
    input  logic                  WbRegWrite,
    input  logic [REG_ADDR_W-1:0] WbWriteRegister,
    input  logic                  Flush,
    input  logic                  ExHold,
    output logic                  LoadUse,
    output logic                  StallID,
    output logic                  BypassRs,
    output logic                  BypassRt,
    output logic                  RefreshRs,
    output logic                  RefreshRt
);

    // Hazard, stall and forwarding selects derived from current EX/ID/WB state.
    always_comb begin
        LoadUse   = ExValid && ExMemRead && (ExRt != REG_ZERO) && IdValid &&
                    ((ExRt == IdRs) || (ExRt == IdRt));
        // Stall is suppressed during reset and whenever the slot is flushed.
        StallID   = Reset && !Flush && (ExHold || LoadUse);
        BypassRs  = wbHits(WbRegWrite, WbWriteRegister, IdRs);
        BypassRt  = wbHits(WbRegWrite, WbWriteRegister, IdRt);
        RefreshRs = ExValid && wbHits(WbRegWrite, WbWriteRegister, ExRs);
        RefreshRt = ExValid && wbHits(WbRegWrite, WbWriteRegister, ExRt);
    end

endmodule

// File: rtl/id_ex_stage_register.sv
// ID/EX pipeline register with write-back bypass, load-use bubble insertion,
// branch flush, downstream hold and a saturating stall-cycle counter.
module id_ex_stage_register
    import id_ex_stage_register_pkg::*;
(
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  ID_Valid,
    input  logic [REG_ADDR_W-1:0] ID_Rs,
    input  logic [REG_ADDR_W-1:0] ID_Rt,
    input  logic [REG_ADDR_W-1:0] ID_Rd,
    input  logic [DATA_W-1:0]     ID_ReadData1,
    input  logic [DATA_W-1:0]     ID_ReadData2,
    input  logic [DATA_W-1:0]     ID_Imm,
    input  logic [DATA_W-1:0]     ID_PCPlus4,
    input  logic [CTRL_W-1:0]     ID_Ctrl,
    input  logic                  ID_MemRead,
    input  logic                  ID_RegWrite,
    input  logic                  WB_RegWrite,
    input  logic [REG_ADDR_W-1:0] WB_WriteRegister,
    input  logic [DATA_W-1:0]     WB_WriteData,
    input  logic                  Flush,
    input  logic                  EX_Hold,
    output logic                  EX_Valid,
    output logic [REG_ADDR_W-1:0] EX_Rs,
    output logic [REG_ADDR_W-1:0] EX_Rt,
    output logic [REG_ADDR_W-1:0] EX_Rd,
    output logic [DATA_W-1:0]     EX_ReadData1,
    output logic [DATA_W-1:0]     EX_ReadData2,
    output logic [DATA_W-1:0]     EX_Imm,
    output logic [DATA_W-1:0]     EX_PCPlus4,
    output logic [CTRL_W-1:0]     EX_Ctrl,
    output logic                  EX_MemRead,
    output logic                  EX_RegWrite,
    output logic                  StallID,
    output logic [31:0]           StallCycles
);

    idExRec_t    pipe_p1;
    idExRec_t    capture_p0;
    logic [31:0] stallCnt_p1;
    logic        loadUse;
    logic        bypassRs;
    logic        bypassRt;
    logic        refreshRs;
    logic        refreshRt;

    function automatic logic [31:0] satInc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

    id_ex_hazard_detect uHazard (
        .Reset           (Reset),
        .ExValid         (pipe_p1.valid),
        .ExMemRead       (pipe_p1.memRead),
        .ExRs            (pipe_p1.rs),
        .ExRt            (pipe_p1.rt),
        .IdValid         (ID_Valid),
        .IdRs            (ID_Rs),
        .IdRt            (ID_Rt),
        .WbRegWrite      (WB_RegWrite),
        .WbWriteRegister (WB_WriteRegister),
        .Flush           (Flush),
        .ExHold          (EX_Hold),
        .LoadUse         (loadUse),
        .StallID         (StallID),
        .BypassRs        (bypassRs),
        .BypassRt        (bypassRt),
        .RefreshRs       (refreshRs),
        .RefreshRt       (refreshRt)
    );

    // Stage p0: assemble the record a normal capture would load, with bypass applied.
    always_comb begin
        capture_p0           = BUBBLE;
        capture_p0.valid     = ID_Valid;
        capture_p0.rs        = ID_Rs;
        capture_p0.rt        = ID_Rt;
        capture_p0.rd        = ID_Rd;
        capture_p0.readData1 = bypassRs ? WB_WriteData : ID_ReadData1;
        capture_p0.readData2 = bypassRt ? WB_WriteData : ID_ReadData2;
        capture_p0.imm       = ID_Imm;
        capture_p0.pcPlus4   = ID_PCPlus4;
        capture_p0.ctrl      = ID_Ctrl;
        // An empty decode slot must never look like a load or a writer downstream.
        capture_p0.memRead   = ID_MemRead && ID_Valid;
        capture_p0.regWrite  = ID_RegWrite && ID_Valid;
    end

    // Stage p1: the EX-side register; flush beats hold beats load-use bubble beats capture.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pipe_p1 <= BUBBLE;
        end else if (Flush) begin
            pipe_p1 <= BUBBLE;
        end else if (EX_Hold) begin
            // Held operands still track write-back so they are not stale on release.
            if (refreshRs) pipe_p1.readData1 <= WB_WriteData;
            if (refreshRt) pipe_p1.readData2 <= WB_WriteData;
        end else if (loadUse) begin
            pipe_p1 <= BUBBLE;
        end else begin
            pipe_p1 <= capture_p0;
        end
    end

    // Count every edge on which decode was held; stop at all-ones.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            stallCnt_p1 <= 32'd0;
        end else if (StallID) begin
            stallCnt_p1 <= satInc(stallCnt_p1);
        end
    end

    assign EX_Valid     = pipe_p1.valid;
    assign EX_Rs        = pipe_p1.rs;
    assign EX_Rt        = pipe_p1.rt;
    assign EX_Rd        = pipe_p1.rd;
    assign EX_ReadData1 = pipe_p1.readData1;
    assign EX_ReadData2 = pipe_p1.readData2;
    assign EX_Imm       = pipe_p1.imm;
    assign EX_PCPlus4   = pipe_p1.pcPlus4;
    assign EX_Ctrl      = pipe_p1.ctrl;
    assign EX_MemRead   = pipe_p1.memRead;
    assign EX_RegWrite  = pipe_p1.regWrite;
    assign StallCycles  = stallCnt_p1;

endmodule
